addertest_pipe: RTL and testbench
=================================

Name: addertest_pipe

Overview:
- Pipelined, parametrised successor to the combinational multi-operand adder test kernel used for fabric timing and area evaluation.
- Computes a fixed alternating accumulate/subtract chain over operands a and b, with one register stage per chain step.
- Uses valid/ready handshakes on both sides with full-pipeline stall under backpressure.
- Counts completed results, so benches and on-fabric monitors can check throughput.

Parameters:
- DATA_WIDTH, 32, width of operands and result; all arithmetic is modulo 2^DATA_WIDTH; legal values >=1.
- STAGES, 10, number of chain steps, equal to the number of pipeline register stages; legal values >=1.
- COUNT_WIDTH, 16, width of the completed-result counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  pipeline can accept a transaction this cycle.
- in_a  input  DATA_WIDTH  operand a.
- in_b  input  DATA_WIDTH  operand b.
- in_mode  input  1  0 = add chain, 1 = subtract chain; travels with its transaction.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_sum  output  DATA_WIDTH  chain result.
- out_count  output  COUNT_WIDTH  number of completed output transfers; wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Chain definition, for step i = 0..STAGES-1:
  - t[0] = a + b (mode 0) or a - b (mode 1).
  - For i >= 1: t[i] = t[i-1] op x_i, where x_i = a for odd i and b for even i, and op is + in mode 0, - in mode 1.
  - out_sum = t[STAGES-1], truncated to DATA_WIDTH.
- Closed form:
  - Mode 0: (1+floor(N/2))*a + (1+floor((N-1)/2))*b.
  - Mode 1: a - b - floor(N/2)*a - floor((N-1)/2)*b, with N = STAGES.
- Pipeline structure:
  - Stage k register holds: valid bit, partial t[k], a, b, mode.
  - Stage 0 computes t[0] from the inputs; stage k computes t[k] from stage k-1.
  - out_valid and out_sum are driven directly from the last stage's valid bit and partial; no combinational path from in_a/in_b to out_sum.
- Advance enable: adv = !out_valid || out_ready.
  - When adv = 1, every stage loads from its predecessor; stage 0 loads in_valid together with the operands.
  - When adv = 0, all stages hold, including bubbles. Bubbles are not collapsed.
- Handshake:
  - in_ready = adv.
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Operands presented while in_ready = 0 are ignored and not captured; the source must hold them.
  - out_sum is stable while out_valid && !out_ready.
- Latency and throughput:
  - A transaction accepted at edge T appears with out_valid = 1 in the cycle after edge T+STAGES-1, i.e. STAGES cycles later, when no stall occurs.
  - Throughput is 1 result per cycle while out_ready = 1.
- Simultaneous events:
  - An output transfer and an input transfer in the same cycle are both honoured, with no bubble inserted.
- Modes:
  - Mixed modes in flight are independent per transaction.
- Counter:
  - out_count increments by 1 on every output transfer.
  - From all-ones it wraps to 0.
- Reset, when rst_n = 0 at an edge:
  - All stage valid bits, partials, captured operands and out_count go to 0.
  - out_valid = 0, out_sum = 0.
  - in_ready reads 1 from the first cycle after reset.
  - Reset applied mid-operation discards all in-flight transactions and overrides stall and transfers in that cycle.
- Width rules:
  - Carries out of bit DATA_WIDTH-1 are discarded.
  - Subtraction wraps two's-complement.
  - No overflow flag.

Test Plan:
- Basic, defaults (W=32, N=10): a=1, b=2, mode 0 -> out_sum=16 exactly 10 cycles after accept; out_count=1. Mode 1 -> out_sum=0xFFFFFFF2 (-14).
- Wrap: a=0xFFFFFFFF, b=0, mode 0 -> 0xFFFFFFFA. a=0x80000000, b=0x80000000, mode 0 -> 0x80000000.
- Streaming: 20 back-to-back transactions, a=k, b=2k, out_ready=1 -> results 16k in order; one per cycle from cycle 10 to 29; out_count=20.
- Backpressure: stream with out_ready low for 5 cycles at result 3 -> in_ready=0 and out_sum held during the stall; no loss or duplication; order preserved.
- Reset mid-flight: 5 in flight, rst_n=0 for 1 cycle -> out_valid=0, out_sum=0, out_count=0 next cycle; no stale result ever emerges.
- Parameter sweep:
  - STAGES=1, W=8: a=200, b=100, mode 0 -> 44 one cycle after accept.
  - STAGES=3: a=1, b=1, mode 0 -> 4; mode 1 -> 0xFE.
  - COUNT_WIDTH=2: 5 results -> out_count=1.

Source files
------------

// File: rtl/addertest_pipe_if.sv
// -----------------------------------------------------------------------------
// addertest_pipe_if
//   Handshake bundle for addertest_pipe: operand side (in_*) and result side
//   (out_*), each with valid/ready flow control, plus the completed-result
//   counter.
//
//   Modports:
//     master - the environment: drives operands and out_ready, observes results.
//     slave  - the pipeline: accepts operands, drives results and in_ready.
//
//   Signals:
//     in_valid, in_ready  operand transaction present / pipeline can accept
//     in_a, in_b          operands (DATA_WIDTH)
//     in_mode             0 = add chain, 1 = subtract chain
//     out_valid, out_ready result present / downstream accepts
//     out_sum             chain result (DATA_WIDTH)
//     out_count           completed output transfers, wraps (COUNT_WIDTH)
// -----------------------------------------------------------------------------
interface addertest_pipe_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_a;
  logic [DATA_WIDTH-1:0]  in_b;
  logic                   in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_sum;
  logic [COUNT_WIDTH-1:0] out_count;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );
endinterface

// File: rtl/addertest_pipe.sv
// -----------------------------------------------------------------------------
// addertest_pipe
//   Pipelined alternating accumulate/subtract chain over operands a and b.
//   Step 0 forms a +/- b; step i (i >= 1) adds or subtracts a (odd i) or
//   b (even i) to the running partial. One register stage per step, so a
//   result leaves STAGES cycles after its operands are accepted.
//
//   The whole pipeline advances together whenever the output register is
//   empty or being drained; otherwise every stage (bubbles included) holds.
//   out_count tallies completed output transfers.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    addertest_pipe_if.slave (operand and result handshakes, counter)
// -----------------------------------------------------------------------------
module addertest_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int STAGES      = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  addertest_pipe_if.slave   bus
);

  // Everything a transaction needs travels with it, so mixed modes in
  // flight stay independent.
  typedef struct packed {
    logic                  valid;
    logic                  mode;
    logic [DATA_WIDTH-1:0] t;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } stage_t;

  stage_t                 stg_q [STAGES];
  stage_t                 stg_d [STAGES];
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   adv;

  // The pipeline moves when the last stage is empty or its result is taken;
  // a stall freezes every stage so no bubble is ever collapsed.
  assign adv = !stg_q[STAGES-1].valid || bus.out_ready;

  // NOTE: every variable written here gets a full assignment on every pass,
  // so no latch can be inferred.
  always_comb begin
    stg_d[0].valid = bus.in_valid;
    stg_d[0].mode  = bus.in_mode;
    stg_d[0].a     = bus.in_a;
    stg_d[0].b     = bus.in_b;
    stg_d[0].t     = bus.in_mode ? (bus.in_a - bus.in_b) : (bus.in_a + bus.in_b);
    for (int k = 1; k < STAGES; k++) begin
      stg_d[k] = stg_q[k-1];
      // Odd steps fold in a, even steps fold in b.
      if ((k % 2) == 1)
        stg_d[k].t = stg_q[k-1].mode ? (stg_q[k-1].t - stg_q[k-1].a)
                                     : (stg_q[k-1].t + stg_q[k-1].a);
      else
        stg_d[k].t = stg_q[k-1].mode ? (stg_q[k-1].t - stg_q[k-1].b)
                                     : (stg_q[k-1].t + stg_q[k-1].b);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the stage array is cleared in full (operands and partials too),
      // so a visible out_sum after reset is always zero, not stale data.
      for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
      count_q <= '0;
    end else begin
      if (adv) stg_q <= stg_d;
      if (stg_q[STAGES-1].valid && bus.out_ready)
        count_q <= count_q + COUNT_WIDTH'(1);
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = stg_q[STAGES-1].valid;
  assign bus.out_sum   = stg_q[STAGES-1].t;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_addertest_pipe.sv
// -----------------------------------------------------------------------------
// tb_addertest_pipe
//   Directed bench for addertest_pipe. Three instances share clk/rst_n:
//     u0 - defaults (W=32, N=10, C=16)
//     u1 - W=8, N=1
//     u2 - W=8, N=3, C=2 (counter wrap)
//   Inputs change 1 time unit after the rising edge; outputs are read there
//   too, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_addertest_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  addertest_pipe_if #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) d0 ();
  addertest_pipe_if #(.DATA_WIDTH(8),  .COUNT_WIDTH(16)) d1 ();
  addertest_pipe_if #(.DATA_WIDTH(8),  .COUNT_WIDTH(2))  d2 ();

  addertest_pipe #(.DATA_WIDTH(32), .STAGES(10), .COUNT_WIDTH(16))
    u0 (.clk(clk), .rst_n(rst_n), .bus(d0.slave));
  addertest_pipe #(.DATA_WIDTH(8),  .STAGES(1),  .COUNT_WIDTH(16))
    u1 (.clk(clk), .rst_n(rst_n), .bus(d1.slave));
  addertest_pipe #(.DATA_WIDTH(8),  .STAGES(3),  .COUNT_WIDTH(2))
    u2 (.clk(clk), .rst_n(rst_n), .bus(d2.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic m, input logic ordy);
    case (sel)
      0: begin d0.in_valid = v; d0.in_a = a;      d0.in_b = b;      d0.in_mode = m; d0.out_ready = ordy; end
      1: begin d1.in_valid = v; d1.in_a = a[7:0]; d1.in_b = b[7:0]; d1.in_mode = m; d1.out_ready = ordy; end
      default: begin d2.in_valid = v; d2.in_a = a[7:0]; d2.in_b = b[7:0]; d2.in_mode = m; d2.out_ready = ordy; end
    endcase
  endtask

  function automatic logic [63:0] obs_valid(input int sel);
    case (sel)
      0: return 64'(d0.out_valid);
      1: return 64'(d1.out_valid);
      default: return 64'(d2.out_valid);
    endcase
  endfunction

  function automatic logic [63:0] obs_ready(input int sel);
    case (sel)
      0: return 64'(d0.in_ready);
      1: return 64'(d1.in_ready);
      default: return 64'(d2.in_ready);
    endcase
  endfunction

  function automatic logic [63:0] obs_sum(input int sel);
    case (sel)
      0: return 64'(d0.out_sum);
      1: return 64'(d1.out_sum);
      default: return 64'(d2.out_sum);
    endcase
  endfunction

  function automatic logic [63:0] obs_count(input int sel);
    case (sel)
      0: return 64'(d0.out_count);
      1: return 64'(d1.out_count);
      default: return 64'(d2.out_count);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction through an idle pipeline with out_ready held high.
  // Latency counts rising edges from the accepting edge up to the one after
  // which out_valid is first seen.
  task automatic run_one(input int sel, input logic [31:0] a, input logic [31:0] b,
                         input logic m, input logic [63:0] exp_sum, input int exp_lat,
                         input logic [63:0] exp_cnt, input string tag);
    int lat;
    drive(sel, 1'b1, a, b, m, 1'b1);
    #1;
    check({tag, " in_ready idle"}, obs_ready(sel), 64'd1);
    tick();
    drive(sel, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    lat = 1;
    while (obs_valid(sel) !== 64'd1 && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " sum"}, obs_sum(sel), exp_sum);
    tick();
    check({tag, " count"}, obs_count(sel), exp_cnt);
    check({tag, " drained"}, obs_valid(sel), 64'd0);
  endtask

  // Back-to-back stream on u0: a=k, b=2k for k=1..n, expected result 16k.
  // With stall_at >= 0, out_ready drops for 5 cycles while result number
  // stall_at (0-based) is presented.
  task automatic stream(input int n, input int stall_at, input int cnt_base, input string tag);
    int  sent = 0, recv = 0, cyc = 0, first = -1, last = -1, stall_left = 5;
    logic acc, dlv;
    while (recv < n && cyc < 300) begin
      d0.in_valid = (sent < n);
      d0.in_a     = 32'(sent + 1);
      d0.in_b     = 32'(2 * (sent + 1));
      d0.in_mode  = 1'b0;
      if (stall_at >= 0 && recv == stall_at && d0.out_valid && stall_left > 0) begin
        d0.out_ready = 1'b0;
        stall_left--;
      end else begin
        d0.out_ready = 1'b1;
      end
      #1;
      if (!d0.out_ready) begin
        check($sformatf("%s stall in_ready c%0d", tag, cyc), 64'(d0.in_ready), 64'd0);
        check($sformatf("%s stall held sum c%0d", tag, cyc), 64'(d0.out_sum), 64'(16 * (recv + 1)));
      end
      acc = d0.in_valid && d0.in_ready;
      dlv = d0.out_valid && d0.out_ready;
      if (dlv) begin
        check($sformatf("%s result %0d", tag, recv + 1), 64'(d0.out_sum), 64'(16 * (recv + 1)));
        if (first < 0) first = cyc;
        last = cyc;
      end
      tick();
      if (acc) sent++;
      if (dlv) recv++;
      cyc++;
    end
    d0.in_valid  = 1'b0;
    d0.out_ready = 1'b1;
    #1;
    check({tag, " received"}, 64'(recv), 64'(n));
    check({tag, " sent"}, 64'(sent), 64'(n));
    check({tag, " first cycle"}, 64'(first), 64'd10);
    check({tag, " last cycle"}, 64'(last), 64'(10 + n - 1 + ((stall_at >= 0) ? 5 : 0)));
    check({tag, " count"}, 64'(d0.out_count), 64'(cnt_base + n));
    check({tag, " no extra"}, 64'(d0.out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset out_valid", obs_valid(0), 64'd0);
    check("reset out_sum", obs_sum(0), 64'd0);
    check("reset out_count", obs_count(0), 64'd0);
    check("reset in_ready", obs_ready(0), 64'd1);

    // Basic and wrap vectors, defaults (N=10)
    run_one(0, 32'd1, 32'd2, 1'b0, 64'd16, 10, 64'd1, "basic add");
    run_one(0, 32'd1, 32'd2, 1'b1, 64'hFFFF_FFF2, 10, 64'd2, "basic sub");
    run_one(0, 32'hFFFF_FFFF, 32'd0, 1'b0, 64'hFFFF_FFFA, 10, 64'd3, "wrap ones");
    run_one(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h8000_0000, 10, 64'd4, "wrap msb");

    // Streaming, then streaming with backpressure
    stream(20, -1, 4, "stream");
    stream(20, 3, 24, "backpressure");

    // Reset with five transactions in flight
    for (int k = 1; k <= 5; k++) begin
      drive(0, 1'b1, 32'(k), 32'(2 * k), 1'b0, 1'b1);
      tick();
    end
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    check("midreset out_valid", obs_valid(0), 64'd0);
    check("midreset out_sum", obs_sum(0), 64'd0);
    check("midreset out_count", obs_count(0), 64'd0);
    check("midreset in_ready", obs_ready(0), 64'd1);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (d0.out_valid) seen++;
      tick();
    end
    check("midreset no stale", 64'(seen), 64'd0);

    // Parameter sweep: N=1, W=8
    run_one(1, 32'd200, 32'd100, 1'b0, 64'd44, 1, 64'd1, "n1 add");
    run_one(1, 32'd200, 32'd100, 1'b1, 64'd100, 1, 64'd2, "n1 sub");

    // Parameter sweep: N=3, W=8, C=2 (counter wraps after 3)
    run_one(2, 32'd1, 32'd1, 1'b0, 64'd4, 3, 64'd1, "n3 add");
    run_one(2, 32'd1, 32'd1, 1'b1, 64'hFE, 3, 64'd2, "n3 sub");
    run_one(2, 32'd10, 32'd3, 1'b0, 64'd26, 3, 64'd3, "n3 add2");
    run_one(2, 32'd10, 32'd3, 1'b1, 64'hFA, 3, 64'd0, "n3 sub2 wrapcnt");
    run_one(2, 32'hFF, 32'h01, 1'b0, 64'd0, 3, 64'd1, "n3 carry");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
